// File: rtl/flow_ctrl.sv
// flow_ctrl: per-stage pipeline flow control for hazards, jumps, divides, bus waits and traps
package flow_pkg;
  localparam int FLOW_WIDTH = 2;
  localparam logic [FLOW_WIDTH-1:0] FLOW_WORK = 2'd0;
  localparam logic [FLOW_WIDTH-1:0] FLOW_STOP = 2'd1;
  localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = 2'd2;
endpackage

module flow_ctrl
  import flow_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_use_i,
  input  logic                   jump_i,
  input  logic                   div_start_i,
  input  logic                   div_done_i,
  input  logic                   bus_wait_i,
  input  logic                   trap_req_i,
  output logic [FLOW_WIDTH-1:0]  flow_pc_o,
  output logic [FLOW_WIDTH-1:0]  flow_id_o,
  output logic [FLOW_WIDTH-1:0]  flow_ex_o,
  output logic [FLOW_WIDTH-1:0]  flow_mem_o,
  output logic [FLOW_WIDTH-1:0]  flow_wb_o,
  output logic                   div_kill_o,
  output logic                   trap_ack_o,
  output logic                   bus_err_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);
  localparam int WCW = $clog2(BUS_TIMEOUT + 1);
  typedef enum logic [2:0] {INIT, RUN, DIV_WAIT, BUS_WAIT, TRAP_FLUSH} state_e;
  state_e state_q, state_d;
  logic pend_q, pend_d, err_q, err_d, trap, tmo;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [STALL_CNT_W-1:0] stall_q;
  assign bus_err_o = err_q;
  assign stall_cnt_o = stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      pend_q <= 1'b0;
      err_q <= 1'b0;
      wcnt_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      err_q <= err_d;
      wcnt_q <= wcnt_d;
      stall_q <= (flow_pc_o != FLOW_WORK && !(&stall_q)) ? stall_q + STALL_CNT_W'(1) : stall_q;
    end
  end
  // a pending divide survives bus waits until its done strobe is seen
  always_comb begin
    state_d = state_q;
    pend_d = pend_q & ~div_done_i;
    wcnt_d = '0;
    err_d = 1'b0;
    div_kill_o = 1'b0;
    trap_ack_o = 1'b0;
    {flow_pc_o, flow_id_o, flow_ex_o, flow_mem_o, flow_wb_o} = {5{FLOW_WORK}};
    trap = trap_req_i & (state_q != INIT) & (state_q != TRAP_FLUSH);
    tmo = (state_q == BUS_WAIT) & bus_wait_i & (wcnt_q == WCW'(BUS_TIMEOUT - 1));
    if (state_q == INIT) begin
      {flow_pc_o, flow_id_o, flow_ex_o, flow_mem_o, flow_wb_o} = {5{FLOW_REFRESH}};
      state_d = RUN;
    end else if (state_q == TRAP_FLUSH) begin
      {flow_pc_o, flow_id_o, flow_ex_o, flow_mem_o, flow_wb_o} = {FLOW_STOP, {4{FLOW_REFRESH}}};
      trap_ack_o = 1'b1;
      state_d = RUN;
    end else if (trap | tmo) begin
      {flow_pc_o, flow_id_o, flow_ex_o, flow_mem_o, flow_wb_o} = trap ? {FLOW_WORK, {4{FLOW_REFRESH}}}
                                                                        : {{4{FLOW_STOP}}, FLOW_REFRESH};
      div_kill_o = pend_q & ~div_done_i;
      pend_d = 1'b0;
      err_d = ~trap;
      state_d = TRAP_FLUSH;
    end else if (bus_wait_i) begin
      {flow_pc_o, flow_id_o, flow_ex_o, flow_mem_o, flow_wb_o} = {{4{FLOW_STOP}}, FLOW_REFRESH};
      wcnt_d = (state_q == BUS_WAIT) ? wcnt_q + WCW'(1) : '0;
      state_d = BUS_WAIT;
    end else if (state_q == BUS_WAIT) begin
      state_d = pend_d ? DIV_WAIT : RUN;
    end else if (state_q == DIV_WAIT) begin
      if (div_done_i) state_d = RUN;
      else {flow_pc_o, flow_id_o, flow_ex_o, flow_mem_o, flow_wb_o} = {{3{FLOW_STOP}}, FLOW_REFRESH, FLOW_WORK};
    end else if (div_start_i) begin
      {flow_pc_o, flow_id_o, flow_ex_o, flow_mem_o, flow_wb_o} = {{3{FLOW_STOP}}, FLOW_REFRESH, FLOW_WORK};
      pend_d = 1'b1;
      state_d = DIV_WAIT;
    end else if (jump_i) begin
      {flow_pc_o, flow_id_o, flow_ex_o, flow_mem_o, flow_wb_o} = {FLOW_WORK, FLOW_REFRESH, FLOW_REFRESH, FLOW_WORK, FLOW_WORK};
    end else if (load_use_i) begin
      {flow_pc_o, flow_id_o, flow_ex_o, flow_mem_o, flow_wb_o} = {FLOW_STOP, FLOW_STOP, FLOW_REFRESH, FLOW_WORK, FLOW_WORK};
    end
  end
endmodule
